// File: rtl/eq_lat_checker.sv
// eq_lat_checker: compares a DUT stream against a LAT-sample delayed reference stream
module eq_lat_checker #(
   parameter int W     = 8,
   parameter int LAT   = 3,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             clr,
   input  logic             en,
   input  logic [W-1:0]     ref_in,
   input  logic [W-1:0]     dut_in,
   output logic             cmp_valid,
   output logic             match,
   output logic             fail,
   output logic [CNT_W-1:0] mismatch_cnt,
   output logic [15:0]      cmp_cnt,
   output logic [W-1:0]     first_ref,
   output logic [W-1:0]     first_dut,
   output logic [15:0]      first_idx,
   output logic [1:0]       state
);
   localparam int FW = $clog2(LAT + 1);
   localparam logic [FW-1:0] FULL = FW'(LAT);
   localparam logic [FW-1:0] LAST = FW'(LAT - 1);
   typedef enum logic [1:0] {WARMUP = 2'd0, CHECK = 2'd1, FAILED = 2'd2} state_t;
   state_t cur, nxt;
   logic [W-1:0] dly [LAT];
   logic [FW-1:0] fill;
   logic do_cmp, miss;
   assign do_cmp = en && !clr && fill == FULL;
   assign miss   = do_cmp && dut_in != dly[LAT-1];
   assign fail   = cur == FAILED;
   assign state  = cur;
   // state register
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) cur <= WARMUP;
      else cur <= nxt;
   // warm-up ends when the delay line fills; the first miss latches FAILED until clr
   always_comb begin
      nxt = cur;
      nxt = clr ? WARMUP :
            (cur == WARMUP && en && fill == LAST) ? CHECK :
            (cur == CHECK && miss) ? FAILED : cur;
   end
   // delay line, fill tracking, compare result, counters and first-miss capture
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         dly          <= '{default: '0};
         fill         <= '0;
         cmp_valid    <= 1'b0;
         match        <= 1'b1;
         mismatch_cnt <= '0;
         cmp_cnt      <= '0;
         first_ref    <= '0;
         first_dut    <= '0;
         first_idx    <= '0;
      end else if (clr) begin
         dly          <= '{default: '0};
         fill         <= '0;
         cmp_valid    <= 1'b0;
         match        <= 1'b1;
         mismatch_cnt <= '0;
         cmp_cnt      <= '0;
         first_ref    <= '0;
         first_dut    <= '0;
         first_idx    <= '0;
      end else begin
         cmp_valid <= do_cmp;
         if (do_cmp) begin
            match <= !miss;
            if (cmp_cnt != '1) cmp_cnt <= cmp_cnt + 16'd1;
         end
         if (miss && mismatch_cnt != '1) mismatch_cnt <= mismatch_cnt + CNT_W'(1);
         if (miss && cur == CHECK) begin
            first_ref <= dly[LAT-1];
            first_dut <= dut_in;
            first_idx <= cmp_cnt;
         end
         if (en) begin
            dly[0] <= ref_in;
            for (int i = 1; i < LAT; i++) dly[i] <= dly[i-1];
            if (fill != FULL) fill <= fill + FW'(1);
         end
      end
   end
endmodule

// File: tb/tb_eq_lat_checker.sv
// tb_eq_lat_checker: randomized scoreboard bench against a queue-based reference model
module tb_eq_lat_checker;
   localparam int LAT = 3;
   logic clk = 1'b0, reset_n, clr, en;
   logic [7:0] ref_in, dut_in;
   logic cmp_valid, match, fail;
   logic [7:0] mismatch_cnt, first_ref, first_dut;
   logic [15:0] cmp_cnt, first_idx;
   logic [1:0] state;
   logic cv2, m2, f2;
   logic [1:0] mm2, st2;
   logic [15:0] cc2, fi2;
   logic [7:0] fr2, fd2;
   int n_chk = 0, n_fail = 0;
   logic [7:0] hist[$];
   bit q[$];
   int cmpc, mmc, fi;
   bit failed, exp_match;
   logic [7:0] fr, fd, e0;

   eq_lat_checker #(.W(8), .LAT(LAT), .CNT_W(8)) dut (
      .clk(clk), .reset_n(reset_n), .clr(clr), .en(en), .ref_in(ref_in), .dut_in(dut_in),
      .cmp_valid(cmp_valid), .match(match), .fail(fail), .mismatch_cnt(mismatch_cnt),
      .cmp_cnt(cmp_cnt), .first_ref(first_ref), .first_dut(first_dut), .first_idx(first_idx),
      .state(state));

   eq_lat_checker #(.W(8), .LAT(LAT), .CNT_W(2)) dut2 (
      .clk(clk), .reset_n(reset_n), .clr(clr), .en(en), .ref_in(ref_in), .dut_in(dut_in),
      .cmp_valid(cv2), .match(m2), .fail(f2), .mismatch_cnt(mm2),
      .cmp_cnt(cc2), .first_ref(fr2), .first_dut(fd2), .first_idx(fi2),
      .state(st2));

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
      n_chk++;
      if (a !== e) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
      end
   endtask

   function automatic void model_clear();
      hist.delete();
      q.delete();
      cmpc = 0; mmc = 0; fi = 0;
      failed = 0; exp_match = 1;
      fr = 0; fd = 0;
   endfunction

   function automatic void model_edge();
      bit ok;
      if (clr) model_clear();
      else if (en) begin
         if (hist.size() == LAT) begin
            ok = dut_in == hist[0];
            q.push_back(ok);
            exp_match = ok;
            if (!ok) begin
               if (!failed) begin
                  failed = 1; fr = hist[0]; fd = dut_in; fi = cmpc;
               end
               mmc++;
            end
            cmpc++;
            void'(hist.pop_front());
         end
         hist.push_back(ref_in);
      end
   endfunction

   function automatic logic [7:0] al();
      return hist.size() == LAT ? hist[0] : 8'($urandom);
   endfunction

   task automatic status();
      chk("state", 32'(state), failed ? 2 : (hist.size() < LAT ? 0 : 1));
      chk("fail", 32'(fail), 32'(failed));
      chk("mismatch_cnt", 32'(mismatch_cnt), mmc > 255 ? 255 : mmc);
      chk("cmp_cnt", 32'(cmp_cnt), cmpc > 65535 ? 65535 : cmpc);
      chk("first_ref", 32'(first_ref), 32'(fr));
      chk("first_dut", 32'(first_dut), 32'(fd));
      chk("first_idx", 32'(first_idx), fi);
      chk("mismatch_cnt_w2", 32'(mm2), mmc > 3 ? 3 : mmc);
      chk("first_ref_w2", 32'(fr2), 32'(fr));
   endtask

   task automatic step(input logic e, input logic [7:0] r, input logic [7:0] d, input logic c);
      en = e; ref_in = r; dut_in = d; clr = c;
      @(posedge clk);
      model_edge();
      @(negedge clk);
      status();
   endtask

   always @(negedge clk) if (reset_n) begin
      bit exp;
      chk("cmp_valid", 32'(cmp_valid), 32'(q.size() != 0));
      if (q.size() != 0) begin
         exp = q.pop_front();
         chk("match", 32'(match), 32'(exp));
      end else chk("match_hold", 32'(match), 32'(exp_match));
   end

   initial begin
      reset_n = 0; clr = 0; en = 0; ref_in = 0; dut_in = 0;
      model_clear();
      repeat (2) @(negedge clk);
      status();
      chk("reset_cmp_valid", 32'(cmp_valid), 0);
      chk("reset_match", 32'(match), 1);
      reset_n = 1;
      for (int k = 1; k <= 20; k++) step(1, 8'(k), al(), 0);
      chk("aligned_no_fail", 32'(fail), 0);
      step(0, 0, 0, 1);
      for (int k = 1; k <= 12; k++) step(1, 8'(k), (cmpc == 3 && hist.size() == LAT) ? 8'hAA : al(), 0);
      chk("dir_first_ref", 32'(first_ref), 32'h04);
      chk("dir_first_dut", 32'(first_dut), 32'hAA);
      chk("dir_first_idx", 32'(first_idx), 3);
      chk("dir_state_failed", 32'(state), 2);
      chk("dir_mismatch_cnt", 32'(mismatch_cnt), 1);
      step(1, 8'h55, 0, 1);
      chk("clr_state", 32'(state), 0);
      chk("clr_fail", 32'(fail), 0);
      chk("clr_cmp_cnt", 32'(cmp_cnt), 0);
      chk("clr_cmp_valid", 32'(cmp_valid), 0);
      for (int k = 1; k <= 3; k++) step(1, 8'(k), 8'hEE, 0);
      chk("clr_warm_cmp_cnt", 32'(cmp_cnt), 0);
      for (int i = 0; i < 16; i++) step(i % 2 == 0, 8'(16 + i), al(), 0);
      chk("toggle_cmp_cnt", 32'(cmp_cnt), 8);
      chk("toggle_fail", 32'(fail), 0);
      e0 = hist[0];
      for (int i = 0; i < 5; i++) step(1, 8'(40 + i), ~al(), 0);
      chk("sat_w2", 32'(mm2), 3);
      chk("sat_w2_first_ref", 32'(fr2), 32'(e0));
      chk("sat_w8", 32'(mismatch_cnt), 5);
      step(0, 0, 0, 1);
      for (int k = 1; k <= 5; k++) step(1, 8'(k), al(), 0);
      #1 reset_n = 0;
      #1 model_clear();
      status();
      chk("async_cmp_valid", 32'(cmp_valid), 0);
      chk("async_match", 32'(match), 1);
      #1 reset_n = 1;
      for (int k = 1; k <= 6; k++) step(1, 8'(k), al(), 0);
      for (int i = 0; i < 400; i++)
         step($urandom_range(0, 3) != 0, 8'($urandom),
              $urandom_range(0, 9) == 0 ? 8'($urandom) : al(), $urandom_range(0, 49) == 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/eq_lat_checker.md
EQ_LAT_CHECKER -- requirements
Module: eq_lat_checker

Interface
REQ-001 SHALL have parameter W, default 8: data width of both compared streams.
REQ-002 SHALL have parameter LAT, default 3, legal range 1..8: reference-to-DUT latency, counted in enabled samples.
REQ-003 SHALL have parameter CNT_W, default 8: mismatch counter width.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port clr, input, 1 bit: synchronous clear of all checker state.
REQ-007 SHALL have port en, input, 1 bit: sample enable; both streams are sampled on edges where en=1.
REQ-008 SHALL have port ref_in, input, W bits: reference (spec) output stream.
REQ-009 SHALL have port dut_in, input, W bits: implementation output stream.
REQ-010 SHALL have port cmp_valid, output, 1 bit: the compare result is valid this cycle.
REQ-011 SHALL have port match, output, 1 bit: result of the last compare.
REQ-012 SHALL have port fail, output, 1 bit: sticky flag, high once any mismatch has occurred.
REQ-013 SHALL have port mismatch_cnt, output, CNT_W bits: saturating count of mismatches.
REQ-014 SHALL have port cmp_cnt, output, 16 bits: saturating count of compares performed.
REQ-015 SHALL have ports first_ref and first_dut, outputs, W bits each: operands of the first mismatch.
REQ-016 SHALL have port first_idx, output, 16 bits: cmp_cnt value at the first mismatch.
REQ-017 SHALL have port state, output, 2 bits: WARMUP=0, CHECK=1, FAILED=2.

Function
REQ-018 SHALL implement a LAT-deep delay line of ref_in that shifts only on edges with en=1; dly[LAT-1] holds the sample taken LAT enabled samples earlier.
REQ-019 SHALL keep a fill counter that increments on each enabled edge and saturates at LAT.
REQ-020 SHALL compare only on edges with en=1 and fill==LAT; each compare tests dut_in == dly[LAT-1], using the delay-line value before that edge's shift.
REQ-021 SHALL register each compare result: on the next cycle cmp_valid=1 and match=result; otherwise cmp_valid=0 and match holds its last value (1-cycle latency).
REQ-022 SHALL increment cmp_cnt on each compare, saturating at 16'hFFFF.
REQ-023 SHALL increment mismatch_cnt on each failing compare, saturating at 2^CNT_W-1.
REQ-024 FSM, WARMUP->CHECK: on the enabled edge where fill reaches LAT; no compare occurs on that edge.
REQ-025 FSM, CHECK->FAILED: on the first failing compare; on that edge SHALL capture first_ref=dly[LAT-1], first_dut=dut_in, and first_idx=cmp_cnt before its increment, and set fail=1.
REQ-026 FSM, FAILED: SHALL remain FAILED until clr or reset; compares and counting continue, and the first_* captures never update again.
REQ-027 Edges with en=0 SHALL change nothing except cmp_valid, which drops to 0.
REQ-028 clr=1 SHALL, on that edge, return to WARMUP and zero the delay line, fill, all counters, fail and first_*; it SHALL set match=1 and cmp_valid=0. clr overrides a simultaneous en.
REQ-029 Saturated counters SHALL hold their value; fail SHALL stay high regardless of counter saturation.

Reset
REQ-030 reset_n=0 SHALL immediately, without waiting for a clock edge, force: state=WARMUP, delay line=0, fill=0, cmp_valid=0, match=1, fail=0, counters=0, first_*=0.
REQ-031 Deassertion of reset_n mid-stream SHALL restart warm-up; no compare SHALL occur before LAT new enabled samples.

Verification
REQ-032 LAT=3, en=1, ref_in=1,2,3,..., dut_in=ref_in delayed 3 samples -> cmp_valid first high 5 cycles after reset release, match=1 throughout, fail=0, mismatch_cnt=0.
REQ-033 Same stream, but the 4th compare sees dut_in=8'hAA against an expected 8'h04 -> fail=1, state=FAILED, first_ref=8'h04, first_dut=8'hAA, first_idx=3, mismatch_cnt=1.
REQ-034 en toggled 1,0,1,0 on an aligned stream -> the delay line advances only on enabled edges, all matches hold, and cmp_cnt equals the number of enabled post-warm-up edges.
REQ-035 CNT_W=2 with 5 consecutive mismatches -> mismatch_cnt saturates at 3, first_* keep the values from the 1st mismatch.
REQ-036 clr asserted together with en while FAILED -> next cycle state=WARMUP, fail=0, counters=0, cmp_valid=0; the following 3 enabled edges produce no compare.
REQ-037 reset_n pulsed low between clock edges during CHECK -> all outputs reach reset values before the next edge, and warm-up restarts.
